// File: rtl/tap_line_ctrl.sv
// Sequencing controller for an 8-stage tapped shift line.
// It tracks which stages hold real bytes and runs the FLUSH and DRAIN sequences.
//   state    | meaning
//   ST_RUN   | accept upstream bytes; shift only on an accepted byte
//   ST_FLUSH | DEPTH zero shifts, discarding the line contents
//   ST_DRAIN | pad-shift, then deliver the remaining real bytes downstream
module tap_line_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush_req,
  input  logic             drain_req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             shift,
  output logic [WIDTH-1:0] sr_data,
  output logic             taps_valid,
  output logic [CW-1:0]    fill_count,
  output logic             busy
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [DEPTH-1:0] vmask;
  logic [FW-1:0]    fcnt;
  logic             in_ready_i;
  logic             shift_i;
  logic             real_in;
  logic             older_empty;

  // After a shift only vmask[DEPTH-1:1] survives, moved down by one.
  assign older_empty = (vmask[DEPTH-1:1] == '0);

  always_comb begin
    state_nxt  = state;
    in_ready_i = 1'b0;
    shift_i    = 1'b0;
    sr_data    = '0;
    out_valid  = 1'b0;
    real_in    = 1'b0;
    case (state)
      ST_RUN: begin
        in_ready_i = !flush_req && !drain_req && (!vmask[0] || out_ready);
        shift_i    = in_valid && in_ready_i;
        sr_data    = in_data;
        out_valid  = vmask[0] && in_valid && !flush_req && !drain_req;
        real_in    = shift_i;
        if (flush_req)
          state_nxt = ST_FLUSH;
        else if (drain_req && (vmask != '0))
          state_nxt = ST_DRAIN;
      end
      ST_FLUSH: begin
        shift_i = 1'b1;
        if (fcnt == FW'(DEPTH - 1))
          state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (flush_req) begin
          state_nxt = ST_FLUSH;
        end else begin
          if (!vmask[0]) begin
            shift_i = 1'b1;
          end else begin
            out_valid = 1'b1;
            shift_i   = out_ready;
          end
          if (shift_i && older_empty)
            state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // The line must never move while reset is held, whatever the inputs do.
  assign in_ready   = in_ready_i && !rst;
  assign shift      = shift_i && !rst;
  assign taps_valid = &vmask;
  assign fill_count = CW'($countones(vmask));
  assign busy       = (state != ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      vmask <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (shift_i)
        vmask <= {real_in, vmask[DEPTH-1:1]};
      if (state == ST_FLUSH) begin
        if (fcnt == FW'(DEPTH - 1)) begin
          fcnt  <= '0;
          vmask <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tap_line_ctrl.sv
// Directed bench for tap_line_ctrl; a behavioural copy of the tapped line
// supplies the sr_out byte the controller is steering.
module tb_tap_line_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush_req;
  logic       drain_req;
  logic       out_ready;
  logic       out_valid;
  logic       shift;
  logic [7:0] sr_data;
  logic       taps_valid;
  logic [3:0] fill_count;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] line_m [8];

  tap_line_ctrl #(.DEPTH(8), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush_req(flush_req), .drain_req(drain_req),
    .out_ready(out_ready), .out_valid(out_valid), .shift(shift),
    .sr_data(sr_data), .taps_valid(taps_valid), .fill_count(fill_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // stage 7 is newest, stage 0 is sr_out
  always @(posedge clk) begin
    if (shift) begin
      for (int i = 0; i < 7; i++) line_m[i] <= line_m[i+1];
      line_m[7] <= sr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    flush_req = 1'b0; drain_req = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_shift", shift, 0);
    chk("rst_in_ready", in_ready, 0);
    tick(); tick();
    chk("rst_shift_held", shift, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_taps", taps_valid, 0);
    chk("post_rst_fill", fill_count, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_shift", shift, 0);
    chk("post_rst_out_valid", out_valid, 0);
    tick();

    // fill 0x01..0x08 with downstream stalled
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      chk("fill_shift", shift, 1);
      chk("fill_out_valid", out_valid, 0);
      if (i == 8) chk("fill_taps_before_last", taps_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("fill_count_8", fill_count, 8);
    chk("fill_taps", taps_valid, 1);
    in_valid = 1'b1; in_data = 8'h09;
    #1;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_shift", shift, 0);
    tick();
    chk("bp_fill_hold", fill_count, 8);
    out_ready = 1'b1;
    #1;
    chk("bp_out_valid", out_valid, 1);
    chk("bp_sr_out", line_m[0], 8'h01);
    chk("bp_shift_go", shift, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_fill_after", fill_count, 8);
    chk("bp_next_sr_out", line_m[0], 8'h02);

    // flush full line
    flush_req = 1'b1;
    #1;
    chk("fl_req_in_ready", in_ready, 0);
    chk("fl_req_busy", busy, 0);
    tick();
    flush_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fl_busy", busy, 1);
      chk("fl_shift", shift, 1);
      chk("fl_sr_data", sr_data, 0);
      chk("fl_out_valid", out_valid, 0);
      chk("fl_in_ready", in_ready, 0);
      tick();
    end
    chk("fl_done_busy", busy, 0);
    chk("fl_done_fill", fill_count, 0);
    chk("fl_done_in_ready", in_ready, 1);

    // partial drain of A1..A3
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      #1;
      chk("pd_push_shift", shift, 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("pd_fill3", fill_count, 3);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("pd_pad_busy", busy, 1);
      chk("pd_pad_shift", shift, 1);
      chk("pd_pad_out_valid", out_valid, 0);
      chk("pd_pad_sr_data", sr_data, 0);
      tick();
    end
    chk("pd_a1_valid", out_valid, 1);
    chk("pd_a1_data", line_m[0], 8'hA1);
    chk("pd_a1_shift", shift, 1);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("pd_stall_shift", shift, 0);
      chk("pd_stall_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("pd_a2_data", line_m[0], 8'hA2);
    chk("pd_a2_shift", shift, 1);
    tick();
    chk("pd_a3_data", line_m[0], 8'hA3);
    chk("pd_a3_valid", out_valid, 1);
    chk("pd_a3_busy", busy, 1);
    tick();
    chk("pd_end_busy", busy, 0);
    chk("pd_end_fill", fill_count, 0);

    // flush and drain together: flush wins (drain would stall with out_ready low)
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    #1;
    tick();
    in_valid = 1'b0;
    flush_req = 1'b1; drain_req = 1'b1;
    tick();
    flush_req = 1'b0; drain_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("pri_busy", busy, 1);
      chk("pri_shift", shift, 1);
      chk("pri_out_valid", out_valid, 0);
      tick();
    end
    chk("pri_end_busy", busy, 0);
    chk("pri_end_fill", fill_count, 0);

    // flush aborting a drain
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 8'hB0 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    tick(); tick();
    chk("ab_mid_busy", busy, 1);
    chk("ab_mid_fill", fill_count, 3);
    flush_req = 1'b1;
    #1;
    chk("ab_no_shift", shift, 0);
    chk("ab_no_valid", out_valid, 0);
    tick();
    flush_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("ab_fl_busy", busy, 1);
      chk("ab_fl_shift", shift, 1);
      tick();
    end
    chk("ab_end_busy", busy, 0);
    chk("ab_end_fill", fill_count, 0);

    // drain on an empty line is ignored
    drain_req = 1'b1;
    #1;
    chk("de_shift", shift, 0);
    tick();
    chk("de_busy", busy, 0);
    drain_req = 1'b0;
    #1;
    chk("de_in_ready", in_ready, 1);

    // reset during cycle 4 of a flush
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("rm_fill8", fill_count, 8);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick(); tick(); tick();
    chk("rm_fill5", fill_count, 5);
    chk("rm_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("rm_shift", shift, 0);
    chk("rm_busy", busy, 0);
    chk("rm_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rm_fill_after", fill_count, 0);
    chk("rm_busy_after", busy, 0);
    chk("rm_in_ready_after", in_ready, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_line_ctrl.md
# tap_line_ctrl

Sequencing controller for the 8-bit × 8-stage tapped shift line (shift enable, `sr_in`, taps at stages 5/3/1, `sr_out` at stage 0). It owns the line's `shift` and `sr_in` inputs and accepts bytes from an upstream valid/ready stream. It tracks which stages hold real data, so `taps_valid` and `out_valid` are exact. It also provides FLUSH (discard) and DRAIN (deliver remaining bytes downstream) sequences. It sits between the upstream byte source and the tapped line; tap consumers qualify tap reads with `taps_valid`.

## Interface
- `DEPTH`, 8: stages in the controlled line.
- `WIDTH`, 8: byte width of `sr_data`/`in_data`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream byte present.
- `in_data` in WIDTH: upstream byte.
- `in_ready` out 1: controller accepts `in_data` this cycle.
- `flush_req` in 1: level request to discard line contents.
- `drain_req` in 1: level request to push remaining real bytes out.
- `out_ready` in 1: downstream accepts the line's `sr_out` byte.
- `out_valid` out 1: line's `sr_out` holds a real byte that is leaving on this cycle's shift.
- `shift` out 1: shift enable to the line.
- `sr_data` out WIDTH: byte driven to the line's `sr_in`.
- `taps_valid` out 1: all DEPTH stages hold real data.
- `fill_count` out clog2(DEPTH+1): number of real stages (4 bits at default).
- `busy` out 1: FLUSH or DRAIN in progress.

## Operation
- Valid mask `vmask[DEPTH-1:0]`: bit DEPTH-1 is the newest stage and bit 0 is the oldest (`sr_out`). On every `shift`, `vmask <= {real, vmask[DEPTH-1:1]}`, where `real` = 1 only for an accepted upstream byte.
- `taps_valid = &vmask`. `fill_count = popcount(vmask)`.
- States: RUN, FLUSH, DRAIN. Reset enters RUN with `vmask` = 0 and `fcnt` = 0. Line contents after reset are don't-care, because `vmask` masks them.
- **RUN**:
  - `in_ready = !flush_req && !drain_req && (!vmask[0] || out_ready)`.
  - `shift = in_valid && in_ready`; `sr_data = in_data`.
  - `out_valid = vmask[0] && in_valid && !flush_req && !drain_req`. The out transfer occurs exactly when `out_valid && shift`.
  - The oldest real byte never leaves the line without `out_ready`. Without new input, the line holds and the taps stay stable.
- **RUN exits**:
  - `flush_req` → FLUSH. This has priority when it is asserted together with `drain_req`.
  - `drain_req` with `vmask != 0` → DRAIN.
  - `drain_req` with `vmask == 0` is ignored and the state stays RUN.
- **FLUSH**:
  - `in_ready = 0`, `sr_data = 0`, `shift = 1`, `out_valid = 0`.
  - `fcnt` counts from 0 to DEPTH-1, giving exactly DEPTH shifts. The state then returns to RUN with `vmask` = 0.
  - `flush_req` is ignored while in FLUSH.
- **DRAIN**:
  - `in_ready = 0`, `sr_data = 0`.
  - If `vmask[0] == 0`, a pad shift occurs: `shift = 1`, `out_valid = 0`.
  - Otherwise `out_valid = 1` and `shift = out_ready`.
  - Exit to RUN on the shift that leaves `vmask` = 0.
  - `flush_req` in DRAIN aborts to FLUSH on the next edge with no shift that cycle; the drained bytes are lost.
- `busy = (state != RUN)`.

## Timing
- All outputs are combinational from state, `vmask`, and the inputs. The line samples `shift`/`sr_data` on the same edge that the controller updates `vmask`.
- Reset values: `in_ready` = 0 while `rst` is high. After reset, `shift` = 0, `out_valid` = 0, `taps_valid` = 0, `fill_count` = 0, `busy` = 0. `shift` is forced to 0 while `rst` is asserted.
- Fill latency: `taps_valid` rises the cycle after the DEPTH-th accepted byte.
- FLUSH takes exactly DEPTH cycles of `busy` = 1; `in_ready` can be 1 on the following cycle.
- DRAIN from fill n with `out_ready` held high takes exactly DEPTH cycles: first DEPTH−n pad shifts, then n outputs. Each low `out_ready` cycle during the output phase adds one cycle.
- Async reset mid-FLUSH or mid-DRAIN: state returns to RUN immediately, with `vmask` and `fcnt` cleared.

## Test plan
- **Reset**: assert `rst` with `in_valid` = 1. Required: `shift` = 0 and `in_ready` = 0. After release: `in_ready` = 1, `taps_valid` = 0, `fill_count` = 0, `busy` = 0.
- **Fill and backpressure**: push 0x01..0x08 back-to-back with `out_ready` = 0. Required: 8 shifts, then `fill_count` = 8 and `taps_valid` = 1. Offer 0x09 with `out_ready` = 0: `in_ready` = 0 and no shift. Raise `out_ready`: `out_valid` = 1 with `sr_out` = 0x01, shift occurs, and `fill_count` stays 8.
- **Partial drain**: push 0xA1, 0xA2, 0xA3, then pulse `drain_req`. Required: 5 pad shifts with `out_valid` = 0, then 0xA1, 0xA2, 0xA3 delivered. With `out_ready` low for 2 cycles before 0xA2, `shift` stays 0 for those cycles. End state: `busy` = 0 and `fill_count` = 0.
- **Flush full line**: `flush_req` with `fill_count` = 8. Required: `busy` = 1 for exactly 8 cycles with `shift` = 1, `sr_data` = 0, and `out_valid` = 0, then `fill_count` = 0 and `in_ready` = 1.
- **Priority/abort**: assert `flush_req` and `drain_req` together, which must enter FLUSH. Separately, raise `flush_req` mid-DRAIN: no shift that cycle, then FLUSH runs 8 cycles. `drain_req` with `fill_count` = 0 leaves `busy` = 0.
- **Reset mid-sequence**: assert `rst` in cycle 4 of FLUSH. Required: `shift` = 0 and `busy` = 0 immediately, and `fill_count` = 0 after release.
